// File: rtl/ddr_tg_pkg.sv
// Shared types and helpers for the DDR AXI traffic generator.
// Latency: n/a (types, constants and a pure function).
// Backpressure: n/a.
package ddr_tg_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_ADDR,
        S_WR_DATA,
        S_WR_WAIT,
        S_RD_ADDR,
        S_RD_DATA,
        S_DONE
    } tg_state_e;

    localparam int TG_ADDR_STEP = 8;
    localparam int TG_TIMEOUT   = 4095;
    localparam int TG_MAX_DW    = 1024;

    // Lane k of a beat at address addr is seed ^ addr ^ k; lanes beyond dw are zero.
    function automatic logic [TG_MAX_DW-1:0] gen_beat(input logic [31:0] seed,
                                                      input logic [31:0] addr,
                                                      input int          dw);
        logic [TG_MAX_DW-1:0] beat;
        beat = '0;
        for (int k = 0; k < TG_MAX_DW / 32; k++) begin
            if (k < dw / 32) begin
                beat[k*32 +: 32] = seed ^ addr ^ 32'(k);
            end
        end
        return beat;
    endfunction

endpackage

// File: rtl/ddr_tg_pattern_chk.sv
// Expected-beat generator (combinational) plus registered read comparator and error counter.
// Latency: exp_dat is 0 cycles from beat_addr; mis/err_cnt update 1 cycle after a checked beat.
// Backpressure: none; every chk_vld cycle is compared. Macro DDR_TG_ERR_CAPTURE_EN adds first-mismatch capture.
module ddr_tg_pattern_chk
    import ddr_tg_pkg::*;
#(
    parameter int ADDR_WIDTH = 28,
    parameter int DATA_WIDTH = 256
) (
    input  logic                  core_clk,
    input  logic                  core_rst,
    input  logic                  clr,
    input  logic [31:0]           seed,
    input  logic [ADDR_WIDTH-1:0] beat_addr,
    input  logic                  chk_vld,
    input  logic [DATA_WIDTH-1:0] act_dat,
    output logic [DATA_WIDTH-1:0] exp_dat,
    output logic                  mis,
    output logic [15:0]           err_cnt
`ifdef DDR_TG_ERR_CAPTURE_EN
    ,
    output logic [ADDR_WIDTH-1:0] err_addr,
    output logic [DATA_WIDTH-1:0] err_exp,
    output logic [DATA_WIDTH-1:0] err_act
`endif
);

    logic        mis_now;
    logic        mis_q, mis_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    // Expected data for the beat being written or read, and the raw compare.
    always_comb begin
        exp_dat = DATA_WIDTH'(gen_beat(seed, 32'(beat_addr), DATA_WIDTH));
        mis_now = chk_vld && (act_dat != exp_dat);
    end

    // Mismatch pulse and saturating mismatch counter, both cleared by a new run.
    always_comb begin
        mis_d     = mis_now;
        err_cnt_d = err_cnt_q;
        if (clr) begin
            mis_d     = 1'b0;
            err_cnt_d = '0;
        end else if (mis_now && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    // Comparator state registers.
    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            mis_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            mis_q     <= mis_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign mis     = mis_q;
    assign err_cnt = err_cnt_q;

`ifdef DDR_TG_ERR_CAPTURE_EN
    logic [ADDR_WIDTH-1:0] cap_addr_q, cap_addr_d;
    logic [DATA_WIDTH-1:0] cap_exp_q, cap_exp_d;
    logic [DATA_WIDTH-1:0] cap_act_q, cap_act_d;

    // Capture only the first mismatch of a run (counter still zero at that beat).
    always_comb begin
        cap_addr_d = cap_addr_q;
        cap_exp_d  = cap_exp_q;
        cap_act_d  = cap_act_q;
        if (clr) begin
            cap_addr_d = '0;
            cap_exp_d  = '0;
            cap_act_d  = '0;
        end else if (mis_now && (err_cnt_q == 16'd0)) begin
            cap_addr_d = beat_addr;
            cap_exp_d  = exp_dat;
            cap_act_d  = act_dat;
        end
    end

    // Capture registers.
    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            cap_addr_q <= '0;
            cap_exp_q  <= '0;
            cap_act_q  <= '0;
        end else begin
            cap_addr_q <= cap_addr_d;
            cap_exp_q  <= cap_exp_d;
            cap_act_q  <= cap_act_d;
        end
    end

    assign err_addr = cap_addr_q;
    assign err_exp  = cap_exp_q;
    assign err_act  = cap_act_q;
`endif

endmodule

// File: rtl/ddr_axi_tg_master.sv
// Traffic generator: per burst writes a seeded pattern, reads it back and checks it (DDR_TG_ERR_CAPTURE_EN adds error capture).
// Latency: start to awvalid 1 cycle; one write beat per wready cycle; read checks registered 1 cycle.
// Backpressure: holds aw/ar until ready; write beats advance only on wready; every rvalid beat is accepted.
module ddr_axi_tg_master
    import ddr_tg_pkg::*;
#(
    parameter int         ADDR_WIDTH = 28,
    parameter int         DATA_WIDTH = 256,
    parameter int         ADDR_STEP  = TG_ADDR_STEP,
    parameter logic [3:0] PORT_ID    = 4'd0,
    parameter int         TIMEOUT    = TG_TIMEOUT
) (
    input  logic                    core_clk,
    input  logic                    core_rst,
    input  logic                    ddr_init_done,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   cfg_start_addr,
    input  logic [3:0]              cfg_len,
    input  logic [15:0]             cfg_num_bursts,
    input  logic [31:0]             cfg_seed,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [15:0]             err_cnt,
    output logic [ADDR_WIDTH-1:0]   axi_awaddr,
    output logic [3:0]              axi_awlen,
    output logic [3:0]              axi_awuser_id,
    output logic                    axi_awuser_ap,
    output logic                    axi_awvalid,
    input  logic                    axi_awready,
    output logic [DATA_WIDTH-1:0]   axi_wdata,
    output logic [DATA_WIDTH/8-1:0] axi_wstrb,
    input  logic                    axi_wready,
    input  logic [3:0]              axi_wusero_id,
    input  logic                    axi_wusero_last,
    output logic [ADDR_WIDTH-1:0]   axi_araddr,
    output logic [3:0]              axi_arlen,
    output logic [3:0]              axi_aruser_id,
    output logic                    axi_aruser_ap,
    output logic                    axi_arvalid,
    input  logic                    axi_arready,
    input  logic [DATA_WIDTH-1:0]   axi_rdata,
    input  logic [3:0]              axi_rid,
    input  logic                    axi_rlast,
    input  logic                    axi_rvalid
`ifdef DDR_TG_ERR_CAPTURE_EN
    ,
    output logic [ADDR_WIDTH-1:0]   err_addr,
    output logic [DATA_WIDTH-1:0]   err_exp,
    output logic [DATA_WIDTH-1:0]   err_act
`endif
);

    localparam int WDW = $clog2(TIMEOUT + 1);

    tg_state_e             state_q, state_d;
    logic [3:0]            beat_q, beat_d;
    logic [3:0]            len_q, len_d;
    logic [15:0]           bursts_q, bursts_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           seed_q, seed_d;
    logic [WDW-1:0]        wdog_q, wdog_d;
    logic                  err_q, err_d;

    logic                  clr, chk_vld, beat_evt, wdog_hit, mis;
    logic [ADDR_WIDTH-1:0] beat_addr, burst_step;
    logic [DATA_WIDTH-1:0] exp_dat;

    assign beat_addr  = addr_q + ADDR_WIDTH'(beat_q) * ADDR_WIDTH'(ADDR_STEP);
    assign burst_step = ADDR_WIDTH'((32'(len_q) + 32'd1) * 32'(ADDR_STEP));
    assign wdog_hit   = (wdog_q == WDW'(TIMEOUT));

    ddr_tg_pattern_chk #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_chk (
        .core_clk  (core_clk),
        .core_rst  (core_rst),
        .clr       (clr),
        .seed      (seed_q),
        .beat_addr (beat_addr),
        .chk_vld   (chk_vld),
        .act_dat   (axi_rdata),
        .exp_dat   (exp_dat),
        .mis       (mis),
        .err_cnt   (err_cnt)
`ifdef DDR_TG_ERR_CAPTURE_EN
        ,
        .err_addr  (err_addr),
        .err_exp   (err_exp),
        .err_act   (err_act)
`endif
    );

    // Next-state, per-burst bookkeeping, protocol checks, watchdog and channel outputs.
    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        len_d    = len_q;
        bursts_d = bursts_q;
        addr_d   = addr_q;
        seed_d   = seed_q;
        err_d    = err_q;
        clr      = 1'b0;
        chk_vld  = 1'b0;
        beat_evt = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && ddr_init_done) begin
                    state_d  = S_WR_ADDR;
                    len_d    = cfg_len;
                    seed_d   = cfg_seed;
                    addr_d   = cfg_start_addr;
                    bursts_d = (cfg_num_bursts == 16'd0) ? 16'd1 : cfg_num_bursts;
                    beat_d   = '0;
                    err_d    = 1'b0;
                    clr      = 1'b1;
                end
            end
            S_WR_ADDR: if (axi_awready) state_d = S_WR_DATA;
            S_WR_DATA: begin
                if (axi_wready) begin
                    beat_evt = 1'b1;
                    if (beat_q == len_q) begin
                        beat_d  = '0;
                        state_d = S_WR_WAIT;
                    end else begin
                        beat_d = beat_q + 4'd1;
                    end
                end
            end
            S_WR_WAIT: begin
                if (axi_wusero_last && (axi_wusero_id == PORT_ID)) begin
                    state_d = S_RD_ADDR;
                end else begin
                    // A completion for another port is a routing fault; keep waiting for ours.
                    if (axi_wusero_last) err_d = 1'b1;
                    if (wdog_hit) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_RD_ADDR: if (axi_arready) state_d = S_RD_DATA;
            S_RD_DATA: begin
                if (axi_rvalid) begin
                    beat_evt = 1'b1;
                    chk_vld  = 1'b1;
                    if (axi_rid != PORT_ID) err_d = 1'b1;
                    if (axi_rlast != (beat_q == len_q)) err_d = 1'b1;
                    if (beat_q == len_q) begin
                        beat_d = '0;
                        if (bursts_q <= 16'd1) begin
                            state_d = S_DONE;
                        end else begin
                            bursts_d = bursts_q - 16'd1;
                            addr_d   = addr_q + burst_step;
                            state_d  = S_WR_ADDR;
                        end
                    end else begin
                        beat_d = beat_q + 4'd1;
                    end
                end else if (wdog_hit) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Data mismatches land one cycle after the beat, possibly in the next state.
        if (mis && !clr) err_d = 1'b1;

        // Watchdog restarts on any state change or beat; it only runs while waiting on the slave.
        if (((state_q == S_WR_WAIT) || (state_q == S_RD_DATA)) && (state_d == state_q) && !beat_evt) begin
            wdog_d = wdog_q + WDW'(1);
        end else begin
            wdog_d = '0;
        end

        // Valids are gated by reset so they drop in the reset cycle itself.
        busy          = (state_q != S_IDLE);
        done          = (state_q == S_DONE);
        err           = err_q;
        axi_awvalid   = (state_q == S_WR_ADDR) && !core_rst;
        axi_arvalid   = (state_q == S_RD_ADDR) && !core_rst;
        axi_awaddr    = addr_q;
        axi_araddr    = addr_q;
        axi_awlen     = len_q;
        axi_arlen     = len_q;
        axi_awuser_id = (state_q == S_WR_ADDR) ? PORT_ID : 4'd0;
        axi_aruser_id = (state_q == S_RD_ADDR) ? PORT_ID : 4'd0;
        axi_awuser_ap = 1'b0;
        axi_aruser_ap = 1'b0;
        axi_wdata     = (state_q == S_WR_DATA) ? exp_dat : '0;
        axi_wstrb     = core_rst ? '0 : '1;
    end

    // State and run-configuration registers.
    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            state_q  <= S_IDLE;
            beat_q   <= '0;
            len_q    <= '0;
            bursts_q <= '0;
            addr_q   <= '0;
            seed_q   <= '0;
            wdog_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            len_q    <= len_d;
            bursts_q <= bursts_d;
            addr_q   <= addr_d;
            seed_q   <= seed_d;
            wdog_q   <= wdog_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_ddr_axi_tg_master.sv
// Bench for ddr_axi_tg_master: reactive slave model plus directed runs with hand-computed expectations.
// Latency: n/a.
// Backpressure: model can stall awready and toggle wready.
module tb_ddr_axi_tg_master;

    localparam int         AW  = 28;
    localparam int         DW  = 256;
    localparam int         TMO = 64;
    localparam logic [3:0] PID = 4'd2;

    logic core_clk = 1'b0;
    always #5 core_clk = ~core_clk;

    logic            core_rst, ddr_init_done, start;
    logic [AW-1:0]   cfg_start_addr;
    logic [3:0]      cfg_len;
    logic [15:0]     cfg_num_bursts;
    logic [31:0]     cfg_seed;
    logic            busy, done, err;
    logic [15:0]     err_cnt;
    logic [AW-1:0]   axi_awaddr, axi_araddr;
    logic [3:0]      axi_awlen, axi_awuser_id, axi_arlen, axi_aruser_id;
    logic            axi_awuser_ap, axi_awvalid, axi_awready, axi_aruser_ap, axi_arvalid, axi_arready;
    logic [DW-1:0]   axi_wdata, axi_rdata;
    logic [DW/8-1:0] axi_wstrb;
    logic            axi_wready, axi_wusero_last, axi_rlast, axi_rvalid;
    logic [3:0]      axi_wusero_id, axi_rid;
`ifdef DDR_TG_ERR_CAPTURE_EN
    logic [AW-1:0]   err_addr;
    logic [DW-1:0]   err_exp, err_act;
`endif

    ddr_axi_tg_master #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .ADDR_STEP  (8),
        .PORT_ID    (PID),
        .TIMEOUT    (TMO)
    ) dut (
        .core_clk        (core_clk),
        .core_rst        (core_rst),
        .ddr_init_done   (ddr_init_done),
        .start           (start),
        .cfg_start_addr  (cfg_start_addr),
        .cfg_len         (cfg_len),
        .cfg_num_bursts  (cfg_num_bursts),
        .cfg_seed        (cfg_seed),
        .busy            (busy),
        .done            (done),
        .err             (err),
        .err_cnt         (err_cnt),
        .axi_awaddr      (axi_awaddr),
        .axi_awlen       (axi_awlen),
        .axi_awuser_id   (axi_awuser_id),
        .axi_awuser_ap   (axi_awuser_ap),
        .axi_awvalid     (axi_awvalid),
        .axi_awready     (axi_awready),
        .axi_wdata       (axi_wdata),
        .axi_wstrb       (axi_wstrb),
        .axi_wready      (axi_wready),
        .axi_wusero_id   (axi_wusero_id),
        .axi_wusero_last (axi_wusero_last),
        .axi_araddr      (axi_araddr),
        .axi_arlen       (axi_arlen),
        .axi_aruser_id   (axi_aruser_id),
        .axi_aruser_ap   (axi_aruser_ap),
        .axi_arvalid     (axi_arvalid),
        .axi_arready     (axi_arready),
        .axi_rdata       (axi_rdata),
        .axi_rid         (axi_rid),
        .axi_rlast       (axi_rlast),
        .axi_rvalid      (axi_rvalid)
`ifdef DDR_TG_ERR_CAPTURE_EN
        ,
        .err_addr        (err_addr),
        .err_exp         (err_exp),
        .err_act         (err_act)
`endif
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference pattern: lane k = seed ^ zero-extended address ^ k.
    function automatic logic [DW-1:0] pat(input logic [31:0] seed, input logic [AW-1:0] a);
        logic [DW-1:0] r;
        for (int k = 0; k < DW / 32; k++) r[k*32 +: 32] = seed ^ {4'b0000, a} ^ k;
        return r;
    endfunction

    // Slave model state and knobs.
    logic [DW-1:0] mem [logic [AW-1:0]];
    logic [AW-1:0] aw_log[$];
    logic [AW-1:0] ar_log[$];
    logic [AW-1:0] aw_first, w_addr, r_addr;
    logic [31:0]   cur_seed;
    int  aw_wait, aw_stall_n, w_left, wl_delay, r_left, rbeat, rd_burst, wbeats, rbeats, corrupt_beat;
    bit  aw_seen, w_phase, w_toggle, corrupt_en, bad_rid_en, no_wlast;

    // Reactive slave: drive inputs at negedge, sample the cycle's handshakes 3ns later.
    initial begin
        aw_wait = 0; aw_stall_n = 0; w_left = 0; wl_delay = 0; r_left = 0; rbeat = 0;
        rd_burst = 0; wbeats = 0; rbeats = 0; corrupt_beat = 0; aw_seen = 0; w_phase = 0;
        w_toggle = 0; corrupt_en = 0; bad_rid_en = 0; no_wlast = 0; cur_seed = '0;
        aw_first = '0; w_addr = '0; r_addr = '0;
        axi_awready = 0; axi_wready = 0; axi_wusero_id = 0; axi_wusero_last = 0;
        axi_arready = 0; axi_rdata = '0; axi_rid = 0; axi_rlast = 0; axi_rvalid = 0;
        forever begin
            @(negedge core_clk);
            axi_awready     = (aw_wait >= aw_stall_n);
            axi_wready      = (w_left > 0) && (!w_toggle || w_phase);
            axi_wusero_last = (wl_delay == 1);
            axi_wusero_id   = PID;
            axi_arready     = 1'b1;
            axi_rvalid      = (r_left > 0);
            axi_rid         = (bad_rid_en && rbeat == 1) ? 4'd7 : PID;
            axi_rlast       = (r_left == 1);
            axi_rdata       = mem.exists(r_addr) ? mem[r_addr] : '0;
            if (corrupt_en && rd_burst == 1 && rbeat == corrupt_beat) axi_rdata[5] = ~axi_rdata[5];
            #3;
            if (core_rst) begin
                w_left = 0; r_left = 0; wl_delay = 0; aw_wait = 0; aw_seen = 0;
            end else begin
                if (axi_awvalid) begin
                    if (!aw_seen) begin
                        aw_first = axi_awaddr;
                        aw_seen  = 1;
                    end else begin
                        chk("awaddr_hold", axi_awaddr, aw_first);
                    end
                    if (axi_awready) begin
                        aw_log.push_back(axi_awaddr);
                        w_left  = int'(axi_awlen) + 1;
                        w_addr  = axi_awaddr;
                        aw_wait = 0;
                        aw_seen = 0;
                    end else begin
                        aw_wait++;
                    end
                end
                if (wl_delay > 0) wl_delay--;
                if (axi_wready) begin
                    chk("wdata", axi_wdata, pat(cur_seed, w_addr));
                    mem[w_addr] = axi_wdata;
                    w_addr = w_addr + 28'd8;
                    w_left--;
                    wbeats++;
                    if (w_left == 0 && !no_wlast) wl_delay = 2;
                end
                w_phase = ~w_phase;
                if (axi_arvalid && axi_arready) begin
                    ar_log.push_back(axi_araddr);
                    r_left = int'(axi_arlen) + 1;
                    r_addr = axi_araddr;
                    rbeat  = 0;
                    rd_burst++;
                end else if (axi_rvalid) begin
                    r_addr = r_addr + 28'd8;
                    r_left--;
                    rbeat++;
                    rbeats++;
                end
            end
        end
    end

    task automatic setup(input logic [AW-1:0] a, input logic [3:0] l, input logic [15:0] nb, input logic [31:0] s);
        aw_log.delete();
        ar_log.delete();
        wbeats = 0; rbeats = 0; rd_burst = 0;
        cur_seed = s;
        cfg_start_addr = a; cfg_len = l; cfg_num_bursts = nb; cfg_seed = s;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge core_clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, output int cyc);
        cyc = 0;
        while (!done && cyc < budget) begin
            @(negedge core_clk);
            cyc++;
        end
        if (!done) chk({tag, "_done_timeout"}, 0, 1);
        @(negedge core_clk);
        chk({tag, "_done_pulse"}, done, 0);
        chk({tag, "_busy_after"}, busy, 0);
        @(negedge core_clk);
    endtask

    int cyc;
    logic [DW-1:0] tmp;

    initial begin
        core_rst = 1; ddr_init_done = 1; start = 0;
        cfg_start_addr = '0; cfg_len = '0; cfg_num_bursts = '0; cfg_seed = '0;
        repeat (3) @(negedge core_clk);
        #1;
        chk("rst_wstrb", axi_wstrb, 0);
        chk("rst_awvalid", axi_awvalid, 0);
        chk("rst_busy", busy, 0);
        core_rst = 0;
        @(negedge core_clk);
        chk("idle_wstrb", axi_wstrb, {32{1'b1}});
        chk("idle_err", err, 0);
        chk("idle_errcnt", err_cnt, 0);
        chk("idle_done", done, 0);
        chk("idle_wdata", axi_wdata, 0);

        // Single clean run.
        setup(28'h100, 4'd3, 16'd1, 32'h1234_5678);
        pulse_start();
        chk("s1_awvalid_lat", axi_awvalid, 1);
        chk("s1_awuser", axi_awuser_id, PID);
        chk("s1_busy", busy, 1);
        wait_done("s1", 200, cyc);
        chk("s1_latency_12ish", (cyc >= 10 && cyc <= 14), 1);
        chk("s1_aw_n", aw_log.size(), 1);
        if (aw_log.size() == 1) chk("s1_awaddr", aw_log[0], 28'h100);
        if (ar_log.size() == 1) chk("s1_araddr", ar_log[0], 28'h100);
        chk("s1_wbeats", wbeats, 4);
        chk("s1_rbeats", rbeats, 4);
        chk("s1_err", err, 0);
        chk("s1_errcnt", err_cnt, 0);

        // Multi-burst with address wrap.
        setup(28'hFFFFFF0, 4'd1, 16'd3, 32'hA5A5_0001);
        pulse_start();
        wait_done("mb", 300, cyc);
        chk("mb_aw_n", aw_log.size(), 3);
        if (aw_log.size() == 3) begin
            chk("mb_awaddr0", aw_log[0], 28'hFFFFFF0);
            chk("mb_awaddr1", aw_log[1], 28'h0000000);
            chk("mb_awaddr2", aw_log[2], 28'h0000010);
        end
        if (ar_log.size() == 3) chk("mb_araddr1", ar_log[1], 28'h0000000);
        chk("mb_wbeats", wbeats, 6);
        chk("mb_err", err, 0);

        // Corrupted read beat 2 of the first burst.
        corrupt_en = 1; corrupt_beat = 2;
        setup(28'h200, 4'd3, 16'd1, 32'hDEAD_BEEF);
        pulse_start();
        wait_done("cor", 200, cyc);
        corrupt_en = 0;
        chk("cor_err", err, 1);
        chk("cor_errcnt", err_cnt, 1);
`ifdef DDR_TG_ERR_CAPTURE_EN
        chk("cor_err_addr", err_addr, 28'h210);
        tmp = pat(32'hDEAD_BEEF, 28'h210);
        chk("cor_err_exp", err_exp, tmp);
        tmp[5] = ~tmp[5];
        chk("cor_err_act", err_act, tmp);
`endif

        // Backpressure: awready stalled 5 cycles, wready toggling.
        aw_stall_n = 5; w_toggle = 1;
        setup(28'h340, 4'd3, 16'd1, 32'h0F0F_0F0F);
        pulse_start();
        wait_done("bp", 200, cyc);
        aw_stall_n = 0; w_toggle = 0;
        chk("bp_wbeats", wbeats, 4);
        if (aw_log.size() == 1) chk("bp_awaddr", aw_log[0], 28'h340);
        chk("bp_err", err, 0);
        chk("bp_errcnt", err_cnt, 0);

        // Wrong rid on one beat.
        bad_rid_en = 1;
        setup(28'h500, 4'd3, 16'd1, 32'h1111_2222);
        pulse_start();
        wait_done("rid", 200, cyc);
        bad_rid_en = 0;
        chk("rid_err", err, 1);
        chk("rid_errcnt", err_cnt, 0);

        // Missing write completion: watchdog ends the run.
        no_wlast = 1;
        setup(28'h600, 4'd1, 16'd1, 32'h3333_4444);
        pulse_start();
        wait_done("tmo", 300, cyc);
        no_wlast = 0;
        chk("tmo_latency", (cyc >= TMO && cyc <= TMO + 12), 1);
        chk("tmo_err", err, 1);
        chk("tmo_ar_n", ar_log.size(), 0);

        // Reset while holding awvalid drops it in the same cycle.
        aw_stall_n = 100;
        setup(28'h700, 4'd3, 16'd1, 32'h5555_6666);
        pulse_start();
        @(negedge core_clk);
        chk("rwa_awvalid_pre", axi_awvalid, 1);
        core_rst = 1;
        #1;
        chk("rwa_awvalid_drop", axi_awvalid, 0);
        @(negedge core_clk);
        core_rst = 0;
        aw_stall_n = 0;

        // Reset in WR_DATA, then start ignored while init not done.
        setup(28'h800, 4'd7, 16'd1, 32'h7777_8888);
        pulse_start();
        repeat (3) @(negedge core_clk);
        core_rst = 1;
        @(negedge core_clk);
        core_rst = 0;
        #1;
        chk("rwd_busy", busy, 0);
        chk("rwd_wdata", axi_wdata, 0);
        chk("rwd_awaddr", axi_awaddr, 0);
        chk("rwd_errcnt", err_cnt, 0);
        ddr_init_done = 0;
        @(negedge core_clk);
        pulse_start();
        repeat (4) @(negedge core_clk);
        chk("noinit_busy", busy, 0);
        chk("noinit_awvalid", axi_awvalid, 0);
        chk("noinit_done", done, 0);
        ddr_init_done = 1;
        setup(28'h400, 4'd2, 16'd2, 32'h9999_AAAA);
        pulse_start();
        wait_done("post", 300, cyc);
        if (aw_log.size() == 2) chk("post_awaddr1", aw_log[1], 28'h418);
        chk("post_aw_n", aw_log.size(), 2);
        chk("post_err", err, 0);
        chk("post_errcnt", err_cnt, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
